// File: rtl/sram_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sram_fifo_pkg
// Shared defaults and types for the SRAM-backed FIFO controller.
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default geometry of the 1w1r macro (32x32)
//   SKID_DEPTH                      : entries in the output skid buffer
//   cnt_t                           : resident-word count for the default macro
//                                     (ADDR_WIDTH+1 bits, holds 0..DEPTH)
//   sk_cnt_t                        : skid occupancy, 0..SKID_DEPTH
// -----------------------------------------------------------------------------
package sram_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int SKID_DEPTH     = 2;

  typedef logic [DEF_ADDR_WIDTH:0] cnt_t;
  typedef logic [1:0]              sk_cnt_t;

endpackage : sram_fifo_pkg

// File: rtl/sram_fifo_skid.sv
// -----------------------------------------------------------------------------
// sram_fifo_skid
// Two-entry output buffer between the SRAM read port and the pop interface.
// Entry 0 is the head and drives head_data directly from a register.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   cap          : capture cap_data into the tail this cycle
//   cap_data     : word returned by the macro read port
//   pop          : head is consumed this cycle (only when sk_cnt != 0)
//   head_data    : current head word (registered)
//   sk_cnt       : number of occupied entries, 0..2
// -----------------------------------------------------------------------------
module sram_fifo_skid
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cap,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output sk_cnt_t               sk_cnt
);

  logic [DATA_WIDTH-1:0] ent_reg  [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] ent_next [SKID_DEPTH];
  sk_cnt_t               cnt_reg;
  sk_cnt_t               cnt_next;
  sk_cnt_t               cnt_after_pop;

  // Pop shifts the queue down first; a capture then lands in the first free
  // slot after that shift, so pop+capture in one cycle keeps word order.
  // The controller never captures into a full buffer without a pop.
  always_comb begin
    cnt_after_pop = cnt_reg - sk_cnt_t'(pop);
    cnt_next      = cnt_after_pop + sk_cnt_t'(cap);
    for (int i = 0; i < SKID_DEPTH; i++) begin
      ent_next[i] = ent_reg[i];
    end
    if (pop) begin
      for (int i = 0; i < SKID_DEPTH - 1; i++) begin
        ent_next[i] = ent_reg[i+1];
      end
    end
    if (cap) begin
      ent_next[cnt_after_pop[0]] = cap_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        ent_reg[i] <= '0;
      end
    end else begin
      cnt_reg <= cnt_next;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        ent_reg[i] <= ent_next[i];
      end
    end
  end

  assign head_data = ent_reg[0];
  assign sk_cnt    = cnt_reg;

endmodule : sram_fifo_skid

// File: rtl/sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sram_fifo_ctrl
// Single-clock FIFO controller using one 1w1r synchronous SRAM macro as
// storage, with a first-word-fall-through pop side sustaining 1 word/cycle.
// Total capacity is DEPTH words in the macro plus 2 in the output skid.
//
// Ports:
//   clk                    : clock (also ties to macro clk0/clk1)
//   rst_n                  : asynchronous active-low reset
//   wr_valid/wr_ready      : push handshake, wr_data is the pushed word
//   rd_valid/rd_ready      : pop handshake, rd_data is the head word
//   sram_csb0/addr0/din0   : macro write port (csb active low), combinational
//   sram_csb1/addr1        : macro read port (csb active low), combinational
//   sram_dout1             : macro read data, valid the cycle after issue
//
// Build option SRAM_FIFO_LEVEL_EN adds:
//   level[ADDR_WIDTH+1:0]  : registered total occupancy (SRAM + in flight + skid)
//   almost_full            : SRAM holds DEPTH-2 or more words
// -----------------------------------------------------------------------------
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
`ifdef SRAM_FIFO_LEVEL_EN
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  almost_full,
`endif
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int                  DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wptr_reg;
  logic [ADDR_WIDTH-1:0] rptr_reg;
  logic [ADDR_WIDTH:0]   mem_cnt_reg;
  logic [ADDR_WIDTH:0]   mem_cnt_next;
  logic                  fip_reg;
  sk_cnt_t               sk_cnt;

  logic                  push;
  logic                  fetch;
  logic                  pop;
  logic [2:0]            occ_next;   // skid words plus in-flight fetch after this cycle

  // Both wr_ready and fetch look only at the registered mem_cnt: a word pushed
  // this cycle cannot be fetched until next cycle, and a slot freed by a fetch
  // cannot be rewritten until next cycle, so the macro never sees a read and a
  // write to the same address in one cycle.  rst_n gates the strobes so the
  // macro stays deselected while reset is held.
  always_comb begin
    wr_ready = rst_n && (mem_cnt_reg < DEPTH_CNT);
    push     = wr_valid && wr_ready;
    pop      = rd_valid && rd_ready;
    occ_next = {1'b0, sk_cnt} + {2'b00, fip_reg} - {2'b00, pop};
    fetch    = rst_n && (mem_cnt_reg != '0) && (occ_next < 3'd2);

    unique case ({push, fetch})
      2'b10:   mem_cnt_next = mem_cnt_reg + 1'b1;
      2'b01:   mem_cnt_next = mem_cnt_reg - 1'b1;
      default: mem_cnt_next = mem_cnt_reg;
    endcase
  end

  // Macro ports: it registers these itself, so they stay combinational.
  assign sram_csb0  = ~push;
  assign sram_addr0 = wptr_reg;
  assign sram_din0  = wr_data;
  assign sram_csb1  = ~fetch;
  assign sram_addr1 = rptr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg    <= '0;
      rptr_reg    <= '0;
      mem_cnt_reg <= '0;
      fip_reg     <= 1'b0;
    end else begin
      if (push) begin
        wptr_reg <= wptr_reg + 1'b1;
      end
      if (fetch) begin
        rptr_reg <= rptr_reg + 1'b1;
      end
      mem_cnt_reg <= mem_cnt_next;
      fip_reg     <= fetch;
    end
  end

  // Read data from last cycle's fetch is captured into the skid tail.
  sram_fifo_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap       (fip_reg),
    .cap_data  (sram_dout1),
    .pop       (pop),
    .head_data (rd_data),
    .sk_cnt    (sk_cnt)
  );

  assign rd_valid = (sk_cnt != '0);

`ifdef SRAM_FIFO_LEVEL_EN
  localparam logic [ADDR_WIDTH:0] AF_CNT = (ADDR_WIDTH+1)'(DEPTH - 2);

  logic [ADDR_WIDTH+1:0] level_reg;
  logic [ADDR_WIDTH+1:0] level_next;

  // Registered from next-state terms so level matches the current occupancy.
  always_comb begin
    level_next = {1'b0, mem_cnt_next}
               + (ADDR_WIDTH+2)'(fetch)
               + (ADDR_WIDTH+2)'(occ_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_reg <= '0;
    end else begin
      level_reg <= level_next;
    end
  end

  assign level       = level_reg;
  assign almost_full = (mem_cnt_reg >= AF_CNT);
`endif

endmodule : sram_fifo_ctrl

// File: tb/tb_sram_fifo_ctrl.sv
`timescale 1ns/1ps
module tb_sram_fifo_ctrl;
  import sram_fifo_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int CAP   = DEPTH + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          sram_csb0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic          sram_csb1;
  logic [AW-1:0] sram_addr1;
  logic [DW-1:0] sram_dout1;
`ifdef SRAM_FIFO_LEVEL_EN
  logic [AW+1:0] level;
  logic          almost_full;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int collisions   = 0;
  logic [DW-1:0] sb [$];

  always #5 clk = ~clk;

  sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
`ifdef SRAM_FIFO_LEVEL_EN
    .level      (level),
    .almost_full(almost_full),
`endif
    .sram_csb0  (sram_csb0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1),
    .sram_dout1 (sram_dout1)
  );

  // Behavioural 1w1r macro: both ports sampled at posedge, read data one cycle later.
  logic [DW-1:0] sram_mem [DEPTH];
  always @(posedge clk) begin
    if (!sram_csb0) sram_mem[sram_addr0] <= sram_din0;
    if (!sram_csb1) sram_dout1 <= sram_mem[sram_addr1];
  end

  always @(posedge clk) begin
    if (!sram_csb0 && !sram_csb1 && (sram_addr0 == sram_addr1)) collisions++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF; rd_ready = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (wr_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
      tests_run++;
      if ({sram_csb0, sram_csb1} !== 2'b11) begin tests_failed++; $display("FAIL reset_csb: got %b want 11", {sram_csb0, sram_csb1}); end
      tests_run++;
      if (rd_valid !== 1'b0 || rd_data !== '0) begin tests_failed++; $display("FAIL reset_rd: got valid=%b data=%h want 0/0", rd_valid, rd_data); end
`ifdef SRAM_FIFO_LEVEL_EN
      tests_run++;
      if (level !== '0) begin tests_failed++; $display("FAIL reset_level: got %0d want 0", level); end
`endif
      cyc();
    end
    rst_n = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (wr_ready !== 1'b1 || rd_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_flags: got wr_ready=%b rd_valid=%b want 1/0", wr_ready, rd_valid); end
      tests_run++;
      if ({sram_csb0, sram_csb1} !== 2'b11) begin tests_failed++; $display("FAIL idle_csb: got %b want 11", {sram_csb0, sram_csb1}); end
      cyc();
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_single();
    // cycle 0: push
    wr_valid = 1'b1; wr_data = 32'hA5A5_0001; rd_ready = 1'b0;
    #1;
    tests_run++;
    if (sram_csb0 !== 1'b0 || sram_addr0 !== 5'd0 || sram_din0 !== 32'hA5A5_0001) begin
      tests_failed++; $display("FAIL single_write: got csb0=%b addr0=%0d din0=%h want 0/0/a5a50001", sram_csb0, sram_addr0, sram_din0);
    end
    cyc();
    // cycle 1: fetch issued
    wr_valid = 1'b0;
    #1;
    tests_run++;
    if (sram_csb1 !== 1'b0 || sram_addr1 !== 5'd0 || rd_valid !== 1'b0) begin
      tests_failed++; $display("FAIL single_fetch: got csb1=%b addr1=%0d rd_valid=%b want 0/0/0", sram_csb1, sram_addr1, rd_valid);
    end
    cyc();
    // cycle 2: read data in flight, captured at the end of this cycle
    #1;
    tests_run++;
    if (rd_valid !== 1'b0 || sram_csb1 !== 1'b1) begin
      tests_failed++; $display("FAIL single_inflight: got rd_valid=%b csb1=%b want 0/1", rd_valid, sram_csb1);
    end
    cyc();
    // cycle 3: head visible, pop it
    rd_ready = 1'b1;
    #1;
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== 32'hA5A5_0001) begin
      tests_failed++; $display("FAIL single_head: got valid=%b data=%h want 1/a5a50001", rd_valid, rd_data);
    end
    cyc();
    rd_ready = 1'b0;
    #1;
    tests_run++;
    if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL single_empty: got rd_valid=%b want 0", rd_valid); end
    cyc();
    $display("[TB] test_single done");
  endtask

  task automatic test_fill();
    rd_ready = 1'b0;
    for (int i = 0; i < CAP; i++) begin
      wr_valid = 1'b1; wr_data = DW'(i);
      #1;
      tests_run++;
      if (wr_ready !== 1'b1) begin tests_failed++; $display("FAIL fill_ready word %0d: got %b want 1", i, wr_ready); end
      cyc();
    end
    wr_data = 32'hDEAD_DEAD;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if (wr_ready !== 1'b0 || sram_csb0 !== 1'b1) begin
        tests_failed++; $display("FAIL full_block: got wr_ready=%b csb0=%b want 0/1", wr_ready, sram_csb0);
      end
`ifdef SRAM_FIFO_LEVEL_EN
      tests_run++;
      if (level !== 7'd34 || almost_full !== 1'b1) begin
        tests_failed++; $display("FAIL full_level: got level=%0d af=%b want 34/1", level, almost_full);
      end
`endif
      cyc();
    end
    wr_valid = 1'b0; rd_ready = 1'b1;
    for (int i = 0; i < CAP; i++) begin
      #1;
      tests_run++;
      if (rd_valid !== 1'b1 || rd_data !== DW'(i)) begin
        tests_failed++; $display("FAIL drain word %0d: got valid=%b data=%h want 1/%h", i, rd_valid, rd_data, DW'(i));
      end
      cyc();
    end
    rd_ready = 1'b0;
    #1;
    tests_run++;
    if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_empty: got rd_valid=%b want 0", rd_valid); end
    cyc();
    $display("[TB] test_fill done");
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int guard = 0;
    int stalls = 0;
    sb.delete();
    wr_valid = 1'b1; rd_ready = 1'b0;
    while (guard < 60) begin
      wr_data = 32'h5000_0000 + DW'(n);
      #1;
      if (!wr_ready) break;
      sb.push_back(wr_data); n++;
      cyc(); guard++;
    end
    tests_run++;
    if (sb.size() != CAP) begin tests_failed++; $display("FAIL b2b_fill_count: got %0d want %0d", sb.size(), CAP); end
    rd_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      #1;
      tests_run++;
      if (rd_valid !== 1'b1) begin
        tests_failed++; $display("FAIL b2b_rd_valid cycle %0d: got 0 want 1", c);
      end else if (sb.size() == 0 || rd_data !== sb[0]) begin
        tests_failed++; $display("FAIL b2b_data cycle %0d: got %h want %h", c, rd_data, (sb.size() != 0) ? sb[0] : '0);
      end
      if (rd_valid && sb.size() != 0) void'(sb.pop_front());
      if (wr_ready) begin sb.push_back(wr_data); n++; end
      else if (c > 0) stalls++;
      cyc();
      wr_data = 32'h5000_0000 + DW'(n);
    end
    tests_run++;
    if (stalls != 0) begin tests_failed++; $display("FAIL b2b_stalls: got %0d want 0", stalls); end
    wr_valid = 1'b0;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      #1;
      if (rd_valid) begin
        tests_run++;
        if (rd_data !== sb[0]) begin tests_failed++; $display("FAIL b2b_drain: got %h want %h", rd_data, sb[0]); end
        void'(sb.pop_front());
      end
      cyc(); guard++;
    end
    tests_run++;
    if (sb.size() != 0 || rd_valid !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_drain_end: got left=%0d rd_valid=%b want 0/0", sb.size(), rd_valid);
    end
    rd_ready = 1'b0;
    tests_run++;
    if (collisions != 0) begin tests_failed++; $display("FAIL b2b_collisions: got %0d want 0", collisions); end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_random();
    int sent = 0;
    int got = 0;
    int maxocc = 0;
    int cycles = 0;
    int bad = 0;
    sb.delete();
    while (got < 10000 && cycles < 80000) begin
      wr_valid = (sent < 10000) && ($urandom_range(0, 9) < 7);
      wr_data  = $urandom;
      rd_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (rd_valid && rd_ready) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++; bad++;
          if (bad < 10) $display("FAIL rand_spurious: got %h want no word", rd_data);
        end else begin
          if (rd_data !== sb[0]) begin
            tests_failed++; bad++;
            if (bad < 10) $display("FAIL rand_data #%0d: got %h want %h", got, rd_data, sb[0]);
          end
          void'(sb.pop_front());
        end
        got++;
      end
      if (wr_valid && wr_ready) begin sb.push_back(wr_data); sent++; end
      if (sb.size() > maxocc) maxocc = sb.size();
      cyc(); cycles++;
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    tests_run++;
    if (got != 10000) begin tests_failed++; $display("FAIL rand_timeout: got %0d words want 10000", got); end
    tests_run++;
    if (maxocc > CAP) begin tests_failed++; $display("FAIL rand_overflow: got occupancy %0d want <= %0d", maxocc, CAP); end
    tests_run++;
    if (collisions != 0) begin tests_failed++; $display("FAIL rand_collisions: got %0d want 0", collisions); end
    $display("[TB] test_random done: %0d words in %0d cycles, peak %0d", got, cycles, maxocc);
  endtask

  task automatic test_reset_mid();
    int k = 0;
    int guard = 0;
    wr_valid = 1'b1; rd_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_data = 32'h7000_0000 + DW'(i);
      #1;
      cyc();
    end
    wr_valid = 1'b0; rd_ready = 1'b1;
    #1;
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h7000_0000) begin
      tests_failed++; $display("FAIL mid_pre_head: got valid=%b data=%h want 1/70000000", rd_valid, rd_data);
    end
    cyc();
    // fetch in flight, one word in skid, three in SRAM
    rd_ready = 1'b0; rst_n = 1'b0;
    #1;
    tests_run++;
    if (rd_valid !== 1'b0 || wr_ready !== 1'b0 || {sram_csb0, sram_csb1} !== 2'b11) begin
      tests_failed++; $display("FAIL mid_reset_now: got rd_valid=%b wr_ready=%b csb=%b want 0/0/11", rd_valid, wr_ready, {sram_csb0, sram_csb1});
    end
    cyc();
    #1;
    tests_run++;
    if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_next: got rd_valid=%b want 0", rd_valid); end
`ifdef SRAM_FIFO_LEVEL_EN
    tests_run++;
    if (level !== '0) begin tests_failed++; $display("FAIL mid_reset_level: got %0d want 0", level); end
`endif
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = 32'h8000_0000 + DW'(i);
      #1;
      tests_run++;
      if (sram_csb0 !== 1'b0 || sram_addr0 !== AW'(i)) begin
        tests_failed++; $display("FAIL mid_wr_addr %0d: got csb0=%b addr0=%0d want 0/%0d", i, sram_csb0, sram_addr0, i);
      end
      if (i == 1) begin
        tests_run++;
        if (sram_csb1 !== 1'b0 || sram_addr1 !== 5'd0) begin
          tests_failed++; $display("FAIL mid_rd_addr: got csb1=%b addr1=%0d want 0/0", sram_csb1, sram_addr1);
        end
      end
      cyc();
    end
    wr_valid = 1'b0; rd_ready = 1'b1;
    while (k < 3 && guard < 20) begin
      #1;
      if (rd_valid) begin
        tests_run++;
        if (rd_data !== 32'h8000_0000 + DW'(k)) begin
          tests_failed++; $display("FAIL mid_readback %0d: got %h want %h", k, rd_data, 32'h8000_0000 + DW'(k));
        end
        k++;
      end
      cyc(); guard++;
    end
    tests_run++;
    if (k != 3) begin tests_failed++; $display("FAIL mid_readback_count: got %0d want 3", k); end
    rd_ready = 1'b0;
    #1;
    tests_run++;
    if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_final_empty: got rd_valid=%b want 0", rd_valid); end
    cyc();
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_sram_fifo_ctrl
